// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage constants, queue entry layout and kseg0/kseg1 VA->PA mapping.
package if_fetch_unit_pkg;

    localparam logic [4:0]  EXC_ADEL         = 5'h04;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
    localparam logic [2:0]  SEG_KSEG0        = 3'b100;
    localparam logic [2:0]  SEG_KSEG1        = 3'b101;
    localparam logic [31:0] KSEG_MASK        = 32'h1FFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [4:0]  exccode;
    } fetch_entry_t;

    function automatic logic [31:0] va_to_pa(input logic [31:0] va);
        if (va[31:29] == SEG_KSEG0 || va[31:29] == SEG_KSEG1) begin
            return va & KSEG_MASK;
        end
        return va;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// In-order fetch queue: registered storage, head visible the cycle after push (no bypass).
// Flush wins over push/pop; a push into a full queue is illegal and asserted against.
module if_fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_push_dat,
    input  logic          i_pop,
    output fetch_entry_t  o_head_dat,
    output logic [CW-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst_n && !i_flush) begin
            assert (!(w_push && r_count == CW'(DEPTH)));
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Decoupled instruction fetch: credit-limited SRAM requests, in-order queue to ID, redirect flush.
// Response reaches out_valid one cycle after inst_data_ok; ID stall throttles requests via credits.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          QDEPTH          = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc,
    output logic [4:0]  out_exccode
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_cancel_cnt;
    logic          r_stalled_exc;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_dat;
    logic          w_credit_ok;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_push_data;
    logic          w_push_exc;
    logic          w_out_valid;
    logic          w_pop;

    // Reserving queue space for every in-flight request keeps pushes from ever hitting a full queue.
    assign w_credit_ok  = (32'(r_outstanding) + 32'(w_count) < 32'(QDEPTH))
                       && (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign inst_req     = rst_n && w_credit_ok && !w_misaligned && !redirect_valid && !r_stalled_exc;
    assign inst_addr    = va_to_pa(r_pc);
    assign w_accept     = inst_req && inst_addr_ok;

    assign w_push_data  = inst_data_ok && (r_cancel_cnt == '0) && !redirect_valid;
    assign w_push_exc   = w_misaligned && !r_stalled_exc && (r_outstanding == '0)
                       && (32'(w_count) < 32'(QDEPTH)) && !redirect_valid;
    assign w_out_valid  = (w_count != '0);
    assign w_pop        = w_out_valid && out_ready && !redirect_valid;

    always_comb begin
        w_push_dat = '0;
        if (w_push_exc) begin
            w_push_dat.pc      = r_pc;
            w_push_dat.exc     = 1'b1;
            w_push_dat.exccode = EXC_ADEL;
        end else begin
            w_push_dat.pc    = r_resp_pc;
            w_push_dat.instr = inst_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_cancel_cnt  <= '0;
            r_stalled_exc <= 1'b0;
        end else if (redirect_valid) begin
            // Everything still pending after this cycle belongs to the old stream.
            r_pc          <= redirect_pc;
            r_resp_pc     <= redirect_pc;
            r_outstanding <= r_outstanding - OW'(inst_data_ok);
            r_cancel_cnt  <= r_outstanding - OW'(inst_data_ok);
            r_stalled_exc <= 1'b0;
        end else begin
            if (w_accept) r_pc <= r_pc + 32'd4;
            r_outstanding <= r_outstanding + OW'(w_accept) - OW'(inst_data_ok);
            if (inst_data_ok && r_cancel_cnt != '0) r_cancel_cnt <= r_cancel_cnt - OW'(1);
            if (w_push_data) r_resp_pc <= r_resp_pc + 32'd4;
            if (w_push_exc) r_stalled_exc <= 1'b1;
        end
    end

    if_fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (redirect_valid),
        .i_push     (w_push_data || w_push_exc),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign out_valid   = w_out_valid;
    assign out_pc      = w_out_valid ? w_head.pc      : 32'd0;
    assign out_instr   = w_out_valid ? w_head.instr   : 32'd0;
    assign out_exc     = w_out_valid ? w_head.exc     : 1'b0;
    assign out_exccode = w_out_valid ? w_head.exccode : 5'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench: in-order SRAM model with random latency, reference PC stream checked at every pop.
module tb_if_fetch_unit;
    localparam int QDEPTH = 4;
    localparam int MAXO   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;
    logic [4:0]  out_exccode;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'hBFC0_0000), .QDEPTH(QDEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc),
        .out_exccode(out_exccode)
    );

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } sreq_t;

    sreq_t       sq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] req_pc;
    logic [31:0] exp_pc;
    bit          exc_done;
    int          n_acc = 0;
    int          n_pop = 0;
    int          n_exc_pop = 0;
    int          k_aok_pct, k_rdy_pct, k_lat_max, k_budget;
    bit          k_redir;
    logic [31:0] k_redir_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] va2pa(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hC000_0000) return va % 32'h2000_0000;
        return va;
    endfunction

    function automatic logic [31:0] hsh(input logic [31:0] pa);
        return pa ^ 32'hC3A5_5A3C ^ {pa[15:0], pa[31:16]};
    endfunction

    // One cycle: drive inputs after negedge, observe settled outputs, update the reference stream.
    task automatic step();
        sreq_t r;
        @(negedge clk);
        cyc++;
        redirect_valid = k_redir;
        redirect_pc    = k_redir_pc;
        inst_addr_ok   = ($urandom_range(99) < k_aok_pct);
        out_ready      = ($urandom_range(99) < k_rdy_pct);
        inst_data_ok   = 1'b0;
        inst_rdata     = $urandom;
        if (sq.size() > 0 && sq[0].rdy <= cyc && k_budget != 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = hsh(sq[0].addr);
            if (k_budget > 0) k_budget--;
        end
        #1;
        if (redirect_valid) chk("req_in_redirect", inst_req, 0);
        else if (req_pc[1:0] != 2'b00) chk("req_misaligned", inst_req, 0);
        if (inst_data_ok) r = sq.pop_front();
        if (inst_req && inst_addr_ok) begin
            chk("inst_addr", inst_addr, va2pa(req_pc));
            r.addr = inst_addr;
            r.rdy  = cyc + 1 + int'($urandom_range(k_lat_max));
            sq.push_back(r);
            req_pc += 32'd4;
            n_acc++;
        end
        if (out_valid && out_ready && !redirect_valid) begin
            n_pop++;
            if (exc_done) begin
                chk("pop_after_exc", out_valid, 0);
            end else begin
                chk("out_pc", out_pc, exp_pc);
                if (exp_pc[1:0] != 2'b00) begin
                    chk("out_exc", out_exc, 1);
                    chk("out_exccode", out_exccode, 5'h04);
                    chk("out_instr_exc", out_instr, 0);
                    exc_done = 1'b1;
                    n_exc_pop++;
                end else begin
                    chk("out_exc", out_exc, 0);
                    chk("out_exccode", out_exccode, 0);
                    chk("out_instr", out_instr, hsh(va2pa(exp_pc)));
                    exp_pc += 32'd4;
                end
            end
        end
        if (redirect_valid) begin
            req_pc   = redirect_pc;
            exp_pc   = redirect_pc;
            exc_done = 1'b0;
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        k_redir    = 1'b1;
        k_redir_pc = pc;
        step();
        k_redir    = 1'b0;
    endtask

    initial begin
        int n, p0, e0, sel;
        logic [31:0] t;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0; inst_rdata = '0; out_ready = 1'b0;
        k_redir = 1'b0; k_redir_pc = '0; k_budget = -1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_inst_req", inst_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_exc", out_exc, 0);
        chk("rst_out_exccode", out_exccode, 0);
        chk("rst_inst_addr", inst_addr, 32'h1FC0_0000);
        rst_n = 1'b1;
        req_pc = 32'hBFC0_0000; exp_pc = 32'hBFC0_0000; exc_done = 1'b0;

        // Streaming at full rate with 1-cycle SRAM latency.
        k_aok_pct = 100; k_rdy_pct = 100; k_lat_max = 0;
        step();
        chk("first_req", inst_req, 1);
        repeat (3) step();
        p0 = n_pop;
        repeat (16) step();
        chk("throughput", n_pop - p0, 16);

        // ID back-pressure: queue fills to QDEPTH and requests stop.
        k_rdy_pct = 0;
        repeat (10) step();
        chk("bp_req_off", inst_req, 0);
        chk("bp_sram_idle", sq.size(), 0);
        chk("bp_queued", n_acc - n_pop, QDEPTH);
        chk("bp_valid", out_valid, 1);
        k_rdy_pct = 100;
        repeat (10) step();

        // Redirect with two requests in flight; both responses must be dropped.
        k_budget = 0;
        n = 0;
        while (sq.size() != 2 && n < 40) begin step(); n++; end
        chk("two_outstanding", sq.size(), 2);
        redirect_to(32'h8000_1000);
        k_budget = -1; k_lat_max = 2;
        repeat (20) step();

        // Misaligned target: single AdEL entry, then stall.
        e0 = n_exc_pop;
        redirect_to(32'h8000_0002);
        repeat (15) step();
        chk("exc_count", n_exc_pop - e0, 1);
        chk("exc_stall_empty", out_valid, 0);

        // Redirect coinciding with data_ok and a pop.
        k_rdy_pct = 0; k_lat_max = 0; k_budget = 0;
        redirect_to(32'h0040_0000);
        n = 0;
        while (!(sq.size() == 2 && out_valid) && n < 40) begin
            k_budget = (sq.size() == 2) ? 1 : 0;
            step();
            n++;
        end
        chk("coinc_setup", sq.size() == 2 && out_valid, 1);
        k_budget = 1; k_rdy_pct = 100;
        redirect_to(32'hA000_2000);
        chk("coinc_inputs", inst_data_ok && out_valid && out_ready, 1);
        k_budget = -1;
        step();
        chk("coinc_flushed", out_valid, 0);
        repeat (20) step();

        // Random traffic with random redirects, including misaligned and wrapping targets.
        k_aok_pct = 60; k_rdy_pct = 70; k_lat_max = 5;
        p0 = n_pop;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) begin
                sel = int'($urandom_range(4));
                t = $urandom & 32'h000F_FFFC;
                case (sel)
                    0: t = 32'h8000_0000 | t;
                    1: t = 32'hA000_0000 | t;
                    2: t = 32'h0040_0000 | t;
                    3: t = 32'hBFC0_0000 | t;
                    default: t = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
                endcase
                if ($urandom_range(99) < 20) t = t | 32'($urandom_range(1, 3));
                redirect_to(t);
            end else begin
                step();
            end
        end
        chk("random_progress", n_pop - p0 > 300, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
